// File: rtl/srt_pkg.sv
// Shared parameters and types for the SRT radix-4 quotient converter.
package srt_pkg;

  localparam int unsigned WIDTH   = 26;
  localparam int unsigned NDIGITS = 13;
  localparam int unsigned CNT_W   = 4;

  typedef logic signed [2:0] digit_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/srt_otf_step.sv
// One on-the-fly conversion step: folds a radix-4 digit into the Q/QM pair (QM == Q - 1 ulp).
module srt_otf_step
  import srt_pkg::*;
(
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_qm,
  input  digit_t           i_digit,
  output logic [WIDTH-1:0] o_q_next,
  output logic [WIDTH-1:0] o_qm_next
);

  logic       w_nonneg;
  logic       w_pos;
  logic [1:0] w_q_lo;
  logic [1:0] w_qm_lo;

  // d and 4+d share their low two bits; d-1 and 3+d likewise, so one pair serves both branches.
  assign w_nonneg = ~i_digit[2];
  assign w_pos    = w_nonneg & (i_digit[1:0] != 2'd0);
  assign w_q_lo   = i_digit[1:0];
  assign w_qm_lo  = i_digit[1:0] - 2'd1;

  assign o_q_next  = w_nonneg ? {i_q[WIDTH-3:0], w_q_lo}  : {i_qm[WIDTH-3:0], w_q_lo};
  assign o_qm_next = w_pos    ? {i_q[WIDTH-3:0], w_qm_lo} : {i_qm[WIDTH-3:0], w_qm_lo};

endmodule

// File: rtl/srt_quotient_converter.sv
// Accumulates 13 radix-4 SRT quotient digits into a 26-bit binary quotient with a valid/ready output.
module srt_quotient_converter
  import srt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             digit_valid,
  input  logic [2:0]       digit,
  input  logic             rem_neg,
  output logic             digit_ready,
  output logic [WIDTH-1:0] quotient,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             digit_err
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qm;
  logic [CNT_W-1:0] r_count;
  logic             r_digit_ready;
  logic [WIDTH-1:0] r_quotient;
  logic             r_q_valid;
  logic             r_digit_err;

  logic             w_illegal;
  digit_t           w_digit_eff;
  logic             w_accept;
  logic             w_last;
  logic             w_load;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_qm_next;

  // The unused encoding -4 is absorbed as a zero digit and flagged.
  assign w_illegal   = (digit == 3'b100);
  assign w_digit_eff = w_illegal ? digit_t'(3'b000) : digit_t'(digit);

  srt_otf_step u_otf_step (
    .i_q       (r_q),
    .i_qm      (r_qm),
    .i_digit   (w_digit_eff),
    .o_q_next  (w_q_next),
    .o_qm_next (w_qm_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_accept = digit_valid;
        w_last   = digit_valid && (r_count == CNT_W'(NDIGITS - 1));
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (q_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q           <= '0;
      r_qm          <= '0;
      r_count       <= '0;
      r_quotient    <= '0;
      r_q_valid     <= 1'b0;
      r_digit_ready <= 1'b0;
      r_digit_err   <= 1'b0;
    end else begin
      r_q_valid     <= (w_state_next == S_DONE);
      r_digit_ready <= (w_state_next == S_ACCUM);
      if (w_load) begin
        r_q         <= '0;
        r_qm        <= '1;
        r_count     <= '0;
        r_digit_err <= 1'b0;
      end else if (w_accept) begin
        r_q         <= w_q_next;
        r_qm        <= w_qm_next;
        r_count     <= r_count + CNT_W'(1);
        r_digit_err <= r_digit_err | w_illegal;
        if (w_last) r_quotient <= rem_neg ? w_qm_next : w_q_next;
      end
    end
  end

  assign digit_ready = r_digit_ready;
  assign quotient    = r_quotient;
  assign q_valid     = r_q_valid;
  assign digit_err   = r_digit_err;

endmodule

// File: tb/tb_srt_quotient_converter.sv
// Randomized bench for srt_quotient_converter against an arithmetic digit-sum reference.
module tb_srt_quotient_converter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        digit_valid;
  logic [2:0]  digit;
  logic        rem_neg;
  logic        digit_ready;
  logic [25:0] quotient;
  logic        q_valid;
  logic        q_ready;
  logic        digit_err;

  int vectors;
  int miscompares;

  logic [2:0] digs [13];
  logic       rn;

  srt_quotient_converter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .digit_valid (digit_valid),
    .digit       (digit),
    .rem_neg     (rem_neg),
    .digit_ready (digit_ready),
    .quotient    (quotient),
    .q_valid     (q_valid),
    .q_ready     (q_ready),
    .digit_err   (digit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quotient = sum d_i * 4^(12-i) mod 2^26, minus one ulp when the remainder is negative.
  function automatic logic [25:0] model();
    longint sum;
    int     d;
    sum = 0;
    for (int i = 0; i < 13; i++) begin
      d = (digs[i] == 3'b100) ? 0 : int'($signed(digs[i]));
      sum = sum * 4 + longint'(d);
    end
    if (rn) sum = sum - 1;
    return 26'(sum);
  endfunction

  function automatic bit model_err();
    bit e;
    e = 1'b0;
    for (int i = 0; i < 13; i++) if (digs[i] == 3'b100) e = 1'b1;
    return e;
  endfunction

  task automatic run_txn(input bit gaps, input int hold, input bit poke);
    logic [25:0] exp_q;
    bit          exp_err;
    int          idx;
    int          cyc;
    exp_q   = model();
    exp_err = model_err();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (digit_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_start: got %b want 1", digit_ready);
    end
    vectors++;
    if (digit_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear_on_start: got %b want 0", digit_err);
    end
    idx = 0;
    cyc = 0;
    while (idx < 13 && cyc < 300) begin
      digit_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      digit       = digs[idx];
      rem_neg     = (idx == 12) ? rn : 1'($urandom);
      start       = poke ? 1'($urandom) : 1'b0;
      if (digit_valid && digit_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    digit_valid = 1'b0;
    start       = 1'b0;
    rem_neg     = 1'b0;
    vectors++;
    if (idx < 13) begin
      miscompares++;
      $display("FAIL digit_timeout: accepted %0d want 13", idx);
    end
    vectors++;
    if (q_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL q_valid_latency: got %b want 1", q_valid);
    end
    vectors++;
    if (quotient !== exp_q) begin
      miscompares++;
      $display("FAIL quotient: got %h want %h", quotient, exp_q);
    end
    vectors++;
    if (digit_err !== exp_err) begin
      miscompares++;
      $display("FAIL digit_err: got %b want %b", digit_err, exp_err);
    end
    vectors++;
    if (digit_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_in_done: got %b want 0", digit_ready);
    end
    for (int h = 0; h < hold; h++) begin
      start       = poke ? 1'($urandom) : 1'b0;
      digit_valid = 1'b1;
      digit       = 3'($urandom_range(0, 7));
      @(negedge clk);
      vectors++;
      if (q_valid !== 1'b1 || quotient !== exp_q) begin
        miscompares++;
        $display("FAIL hold_stable: q_valid %b quotient %h want 1 %h", q_valid, quotient, exp_q);
      end
    end
    start       = 1'b0;
    digit_valid = 1'b0;
    q_ready     = 1'b1;
    @(negedge clk);
    q_ready = 1'b0;
    vectors++;
    if (q_valid !== 1'b0 || digit_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL handshake_release: q_valid %b ready %b want 0 0", q_valid, digit_ready);
    end
    vectors++;
    if (digit_err !== exp_err) begin
      miscompares++;
      $display("FAIL err_sticky_idle: got %b want %b", digit_err, exp_err);
    end
  endtask

  task automatic fill_const(input logic [2:0] v, input logic r);
    for (int i = 0; i < 13; i++) digs[i] = v;
    rn = r;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (quotient !== 26'd0 || q_valid !== 1'b0 || digit_ready !== 1'b0 || digit_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: q %h v %b r %b e %b want all 0", quotient, q_valid, digit_ready, digit_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    fill_const(3'b000, 1'b0);
    run_txn(1'b0, 0, 1'b0);
  endtask

  task automatic test_ones();
    fill_const(3'b001, 1'b0);
    run_txn(1'b0, 1, 1'b0);
    fill_const(3'b111, 1'b0);
    run_txn(1'b0, 1, 1'b0);
  endtask

  task automatic test_edges();
    fill_const(3'b000, 1'b0);
    digs[0]  = 3'b001;
    digs[12] = 3'b111;
    run_txn(1'b0, 0, 1'b0);
    fill_const(3'b000, 1'b1);
    run_txn(1'b0, 0, 1'b0);
    fill_const(3'b011, 1'b0);
    run_txn(1'b0, 0, 1'b0);
    fill_const(3'b101, 1'b1);
    run_txn(1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 13; i++) digs[i] = 3'($urandom_range(0, 6) - 3);
      rn = 1'($urandom);
      run_txn(1'b1, 5, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 6) begin
      digit_valid = 1'b1;
      digit       = (n == 2) ? 3'b100 : 3'($urandom_range(0, 7));
      @(negedge clk);
      n++;
    end
    digit_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (quotient !== 26'd0 || q_valid !== 1'b0 || digit_ready !== 1'b0 || digit_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: q %h v %b r %b e %b want all 0", quotient, q_valid, digit_ready, digit_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      digit_valid = 1'b1;
      digit       = 3'b001;
      @(negedge clk);
      vectors++;
      if (digit_ready !== 1'b0 || q_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_after_reset: ready %b q_valid %b want 0 0", digit_ready, q_valid);
      end
    end
    digit_valid = 1'b0;
    for (int i = 0; i < 13; i++) digs[i] = 3'($urandom_range(0, 6) - 3);
    rn = 1'($urandom);
    run_txn(1'b1, 2, 1'b0);
  endtask

  task automatic test_digit_err();
    fill_const(3'b000, 1'b0);
    digs[$urandom_range(0, 12)] = 3'b100;
    run_txn(1'b0, 1, 1'b0);
    fill_const(3'b001, 1'b0);
    run_txn(1'b0, 0, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    digit_valid = 1'b0;
    digit       = 3'b000;
    rem_neg     = 1'b0;
    q_ready     = 1'b0;
    test_reset();
    test_zero();
    test_ones();
    test_edges();
    test_random();
    test_reset_mid();
    test_digit_err();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
